// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore FSM sequencing the shared ALU/memory datapath,
// holding the NZCV flags and evaluating branch conditions.
module multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [3:0] Funct,
    input  logic [3:0] ALUFlags,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUControl,
    output logic [1:0] ResultSrc,
    output logic [1:0] ImmSrc,
    output logic [3:0] State
);
    typedef enum logic [3:0] {
        FETCH, DECODE, EXEC_R, EXEC_I, ALU_WB, MEM_ADR,
        MEM_RD, MEM_WB, MEM_WR, BRANCH, MOVI
    } state_t;
    state_t state, next;
    logic [3:0] flags;
    logic cond_ex;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH;
            flags <= 4'b0000;
        end else begin
            state <= next;
            if ((state == EXEC_R || state == EXEC_I) && Funct[0])
                flags <= ALUFlags;
        end
    end
    // flags = {N,Z,C,V}
    assign cond_ex = Funct[2:1] == 2'b00 ? 1'b1 :
                     Funct[2:1] == 2'b01 ? flags[2] :
                     Funct[2:1] == 2'b10 ? !flags[2] : flags[3] ^ flags[0];
    always_comb begin
        next       = FETCH;
        PCWrite    = 1'b0;
        IRWrite    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUControl = 2'b00;
        ResultSrc  = 2'b00;
        ImmSrc     = Op == 2'b11 ? 2'b00 : Op == 2'b10 ? 2'b10 : 2'b01;
        State      = state;
        case (state)
            FETCH: begin
                IRWrite   = 1'b1;
                PCWrite   = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                next      = DECODE;
            end
            DECODE: next = Op == 2'b00 ? (Funct[3] ? EXEC_I : EXEC_R) :
                           Op == 2'b01 ? MEM_ADR : Op == 2'b10 ? BRANCH : MOVI;
            EXEC_R: begin
                ALUControl = Funct[2:1];
                next       = ALU_WB;
            end
            EXEC_I: begin
                ALUSrcB    = 2'b01;
                ALUControl = Funct[2:1];
                next       = ALU_WB;
            end
            ALU_WB: RegWrite = 1'b1;
            MEM_ADR: begin
                ALUSrcB = 2'b01;
                next    = Funct[0] ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                AdrSrc = 1'b1;
                next   = MEM_WB;
            end
            MEM_WB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            MEM_WR: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            BRANCH: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                PCWrite   = cond_ex;
            end
            MOVI: begin
                ResultSrc = 2'b11;
                RegWrite  = 1'b1;
            end
            default: ;
        endcase
        // reset silences every output combinationally, not just at the next edge
        if (reset) begin
            PCWrite    = 1'b0;
            IRWrite    = 1'b0;
            MemWrite   = 1'b0;
            RegWrite   = 1'b0;
            AdrSrc     = 1'b0;
            ALUSrcA    = 1'b0;
            ALUSrcB    = 2'b00;
            ALUControl = 2'b00;
            ResultSrc  = 2'b00;
            ImmSrc     = 2'b00;
            State      = 4'd0;
        end
    end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: scoreboard bench; driver pushes per-cycle expected
// controls from an instruction-level model, monitor compares on each negedge.
module tb_multicycle_controller;
    logic clk = 1'b0, reset = 1'b1;
    logic [1:0] Op = 2'b00;
    logic [3:0] Funct = 4'b0000, ALUFlags = 4'b0000;
    logic PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ALUSrcA;
    logic [1:0] ALUSrcB, ALUControl, ResultSrc, ImmSrc;
    logic [3:0] State;
    logic [17:0] act;
    logic [17:0] q[$];
    logic [3:0] model_flags = 4'b0000;
    int checks = 0, failures = 0, cyc = 0;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .ALUFlags(ALUFlags),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
        .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .State(State)
    );

    always #5 clk = ~clk;
    assign act = {PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ALUSrcA,
                  ALUSrcB, ALUControl, ResultSrc, ImmSrc, State};

    function automatic logic [17:0] ctl(input int st, input logic pcw, irw, mw, rw, adr, srca,
                                        input logic [1:0] srcb, aluc, res, imm);
        return {pcw, irw, mw, rw, adr, srca, srcb, aluc, res, imm, 4'(st)};
    endfunction

    task automatic check(input string name, input logic [17:0] got, exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
        end
    endtask

    // Instruction-level model: expands one instruction into its cycle-by-cycle controls.
    task automatic issue(input logic [1:0] op, input logic [3:0] fn, af, output int len);
        logic [1:0] imm;
        logic n, z, v, taken;
        imm = op == 2'b11 ? 2'b00 : op == 2'b10 ? 2'b10 : 2'b01;
        Op = op; Funct = fn; ALUFlags = af;
        q.push_back(ctl(0, 1, 1, 0, 0, 0, 1, 2'b10, 2'b00, 2'b10, imm));
        q.push_back(ctl(1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, imm));
        case (op)
            2'b00: begin
                q.push_back(ctl(fn[3] ? 3 : 2, 0, 0, 0, 0, 0, 0, fn[3] ? 2'b01 : 2'b00, fn[2:1], 2'b00, imm));
                q.push_back(ctl(4, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, imm));
                if (fn[0]) model_flags = af;
            end
            2'b01: begin
                q.push_back(ctl(5, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, imm));
                if (fn[0]) begin
                    q.push_back(ctl(6, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, imm));
                    q.push_back(ctl(7, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b01, imm));
                end else
                    q.push_back(ctl(8, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, imm));
            end
            2'b10: begin
                n = model_flags[3]; z = model_flags[2]; v = model_flags[0];
                case (fn[2:1])
                    2'b00: taken = 1'b1;
                    2'b01: taken = z;
                    2'b10: taken = !z;
                    default: taken = n != v;
                endcase
                q.push_back(ctl(9, taken, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b10, imm));
            end
            default: q.push_back(ctl(10, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b11, imm));
        endcase
        len = op == 2'b00 ? 4 : op == 2'b01 ? (fn[0] ? 5 : 4) : 3;
    endtask

    task automatic run(input logic [1:0] op, input logic [3:0] fn, af);
        int len;
        issue(op, fn, af, len);
        repeat (len) @(posedge clk);
        #1;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (q.size() > 0) check($sformatf("cycle%0d", cyc), act, q.pop_front());
        end
    end

    initial begin
        logic [10:0] dir[12];
        dir = '{{2'b00, 4'b0001, 4'b0100}, {2'b00, 4'b1110, 4'b1011}, {2'b10, 4'b0010, 4'b0000},
                {2'b01, 4'b0001, 4'b0000}, {2'b01, 4'b0000, 4'b0000}, {2'b00, 4'b0011, 4'b0000},
                {2'b10, 4'b0010, 4'b0000}, {2'b00, 4'b0001, 4'b1000}, {2'b10, 4'b0110, 4'b0000},
                {2'b00, 4'b0001, 4'b1001}, {2'b10, 4'b0110, 4'b0000}, {2'b11, 4'b0000, 4'b0000}};
        repeat (2) @(posedge clk);
        #1 check("reset_outputs", act, 18'h0);
        reset = 1'b0;
        #1 check("fetch_after_reset", act, ctl(0, 1, 1, 0, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b01));
        foreach (dir[i]) run(dir[i][10:9], dir[i][8:5], dir[i][4:1]);
        for (int i = 0; i < 150; i++)
            run(2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom));
        run(2'b00, 4'b0001, 4'b0100);
        Op = 2'b01; Funct = 4'b0000;
        repeat (3) @(posedge clk);
        #1 check("in_mem_wr", act, ctl(8, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b01));
        #1 reset = 1'b1;
        #1 check("reset_abort_mem_wr", act, 18'h0);
        @(posedge clk);
        #1 check("reset_held", act, 18'h0);
        reset = 1'b0;
        model_flags = 4'b0000;
        #1 check("fetch_after_release", act, ctl(0, 1, 1, 0, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b01));
        run(2'b10, 4'b0100, 4'b0000);
        run(2'b10, 4'b0010, 4'b0000);
        for (int i = 0; i < 40; i++)
            run(2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom));
        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain left=%0d exp=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
